sram_arb: RTL and testbench

Two-port arbiter placed between two SRAM requesters (the RAM tester and a host/UART-driven port) and the single `sram_top` request interface. It grants the SRAM to one requester at a time with round-robin fairness. It forwards the granted requester's command fields and steers returned read data back to the requester that issued each read, using an in-order tag FIFO.

---
 rtl/sram_arb.sv | 221 ++++++++++++++++++++++
 tb/tb_sram_arb.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arb.sv
// sram_arb: round-robin arbiter between two SRAM requesters and one
// sram_top command port. Read data is steered back to the issuing
// requester through an in-order tag FIFO.
// Optional feature macro: SRAM_ARB_BURST_EN (burst grouping, up to
// MAX_BURST accepted transfers per grant while the other side waits).
module sram_arb #(
  parameter int RD_FIFO_DEPTH = 4,
  parameter int MAX_BURST     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  output logic        m0_ready,
  input  logic        m0_rd,
  input  logic [17:0] m0_addr,
  input  logic [1:0]  m0_be,
  input  logic [15:0] m0_wr_data,
  output logic        m0_rd_data_vld,
  output logic [15:0] m0_rd_data,
  input  logic        m1_req,
  output logic        m1_ready,
  input  logic        m1_rd,
  input  logic [17:0] m1_addr,
  input  logic [1:0]  m1_be,
  input  logic [15:0] m1_wr_data,
  output logic        m1_rd_data_vld,
  output logic [15:0] m1_rd_data,
  output logic        sram_req,
  input  logic        sram_ready,
  output logic        sram_rd,
  output logic [17:0] sram_addr,
  output logic [1:0]  sram_be,
  output logic [15:0] sram_wr_data,
  input  logic        sram_rd_data_vld,
  input  logic [15:0] sram_rd_data,
  output logic        rd_err
);

  localparam int PW = $clog2(RD_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FIFO_FULL_CNT = CW'(RD_FIFO_DEPTH);

  if (RD_FIFO_DEPTH < 2 || (RD_FIFO_DEPTH & (RD_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sram_arb: RD_FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (MAX_BURST < 1) begin : g_bad_burst
    $error("sram_arb: MAX_BURST must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  // Fair choice between requesters; 'last' loses a tie.
  function automatic state_t rr_pick(input logic last, input logic r0, input logic r1);
    state_t s;
    s = IDLE;
    if (r0 && r1) s = last ? OWN0 : OWN1;
    else if (r0)  s = OWN0;
    else if (r1)  s = OWN1;
    return s;
  endfunction

  state_t          state_q, state_d;
  logic            last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [RD_FIFO_DEPTH-1:0] tag_q, tag_d;
  logic            rd_err_q, rd_err_d;

  logic own_id, own_req, oth_req, own_rd;
  logic fifo_full, fifo_empty, blk;
  logic accept, push, pop, head_tag;
  logic hand_ok;

  assign own_id     = (state_q == OWN1);
  assign own_req    = own_id ? m1_req : m0_req;
  assign oth_req    = own_id ? m0_req : m1_req;
  assign own_rd     = own_id ? m1_rd  : m0_rd;
  assign fifo_full  = (cnt_q == FIFO_FULL_CNT);
  assign fifo_empty = (cnt_q == '0);
  // A read cannot be issued without a free tag slot; writes always pass.
  assign blk        = own_rd && fifo_full;
  assign accept     = sram_req && sram_ready;
  assign push       = accept && sram_rd;
  assign pop        = sram_rd_data_vld && !fifo_empty;
  assign head_tag   = tag_q[rptr_q];

`ifdef SRAM_ARB_BURST_EN
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_BURST);
  logic [BW-1:0] bcnt_q, bcnt_d;

  // The owner yields only once this accept completes its burst.
  assign hand_ok = (bcnt_q >= BURST_LAST);

  // Burst counter: clears on any grant change, saturates otherwise.
  always_comb begin
    bcnt_d = bcnt_q;
    if (state_d != state_q)                   bcnt_d = '0;
    else if (accept && bcnt_q != BURST_MAX)   bcnt_d = bcnt_q + BW'(1);
  end

  // Burst counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bcnt_q <= '0;
    else       bcnt_q <= bcnt_d;
  end
`else
  assign hand_ok = 1'b1;
`endif

  // FSM state register and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Next grant: hold while a command is pending, hand over after an accept.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: state_d = rr_pick(last_q, m0_req, m1_req);
      OWN0, OWN1: begin
        if (accept) begin
          last_d = own_id;
          if (oth_req && hand_ok) state_d = own_id ? OWN0 : OWN1;
          else if (!own_req)      state_d = IDLE;
        end else if (!own_req) begin
          last_d  = own_id;
          state_d = rr_pick(own_id, m0_req, m1_req);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Command mux: forward the owner's fields, zero everything in IDLE.
  always_comb begin
    sram_req     = 1'b0;
    sram_rd      = 1'b0;
    sram_addr    = '0;
    sram_be      = '0;
    sram_wr_data = '0;
    m0_ready     = 1'b0;
    m1_ready     = 1'b0;
    case (state_q)
      OWN0: begin
        sram_req     = m0_req && !blk;
        m0_ready     = sram_ready && !blk;
        sram_rd      = m0_rd;
        sram_addr    = m0_addr;
        sram_be      = m0_be;
        sram_wr_data = m0_wr_data;
      end
      OWN1: begin
        sram_req     = m1_req && !blk;
        m1_ready     = sram_ready && !blk;
        sram_rd      = m1_rd;
        sram_addr    = m1_addr;
        sram_be      = m1_be;
        sram_wr_data = m1_wr_data;
      end
      default: ;
    endcase
  end

  // Tag FIFO bookkeeping and sticky error on a return with nothing queued.
  always_comb begin
    cnt_d    = cnt_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    tag_d    = tag_q;
    rd_err_d = rd_err_q;
    if (push) begin
      tag_d[wptr_q] = own_id;
      wptr_d        = wptr_q + PW'(1);
    end
    if (pop) rptr_d = rptr_q + PW'(1);
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!push && pop) cnt_d = cnt_q - CW'(1);
    if (sram_rd_data_vld && fifo_empty) rd_err_d = 1'b1;
  end

  // Tag FIFO control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      rd_err_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      rd_err_q <= rd_err_d;
    end
  end

  // Tag storage; contents are only meaningful below the count.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

  assign m0_rd_data_vld = pop && !head_tag;
  assign m1_rd_data_vld = pop &&  head_tag;
  assign m0_rd_data     = sram_rd_data;
  assign m1_rd_data     = sram_rd_data;
  assign rd_err         = rd_err_q;

endmodule

// File: tb/tb_sram_arb.sv
// Bench for sram_arb: requester agents, an SRAM model and a scoreboard of
// expected grants and read returns.
module tb_sram_arb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic        m0_ready, m1_ready;
  logic        m0_rd = 1'b0, m1_rd = 1'b0;
  logic [17:0] m0_addr = '0, m1_addr = '0;
  logic [1:0]  m0_be = '0, m1_be = '0;
  logic [15:0] m0_wr_data = '0, m1_wr_data = '0;
  logic        m0_rd_data_vld, m1_rd_data_vld;
  logic [15:0] m0_rd_data, m1_rd_data;
  logic        sram_req;
  logic        sram_ready = 1'b1;
  logic        sram_rd;
  logic [17:0] sram_addr;
  logic [1:0]  sram_be;
  logic [15:0] sram_wr_data;
  logic        sram_rd_data_vld = 1'b0;
  logic [15:0] sram_rd_data = '0;
  logic        rd_err;

  always #5 clk = ~clk;

  sram_arb #(.RD_FIFO_DEPTH(4), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_ready(m0_ready), .m0_rd(m0_rd), .m0_addr(m0_addr),
    .m0_be(m0_be), .m0_wr_data(m0_wr_data),
    .m0_rd_data_vld(m0_rd_data_vld), .m0_rd_data(m0_rd_data),
    .m1_req(m1_req), .m1_ready(m1_ready), .m1_rd(m1_rd), .m1_addr(m1_addr),
    .m1_be(m1_be), .m1_wr_data(m1_wr_data),
    .m1_rd_data_vld(m1_rd_data_vld), .m1_rd_data(m1_rd_data),
    .sram_req(sram_req), .sram_ready(sram_ready), .sram_rd(sram_rd),
    .sram_addr(sram_addr), .sram_be(sram_be), .sram_wr_data(sram_wr_data),
    .sram_rd_data_vld(sram_rd_data_vld), .sram_rd_data(sram_rd_data),
    .rd_err(rd_err)
  );

  typedef struct packed { logic rd; logic [17:0] addr; logic [15:0] wd; } cmd_t;
  typedef struct packed { logic id; logic [17:0] addr; } gnt_t;
  typedef struct packed { logic id; logic [15:0] data; } rdx_t;
  typedef struct packed { logic [31:0] due; logic [15:0] data; } ret_t;

  cmd_t q0[$], q1[$];
  gnt_t gexp[$];
  rdx_t rexp[$];
  ret_t retq[$];
  logic [15:0] mem [0:255];

  int   total = 0, bad = 0;
  int   cyc = 0;
  int   acc_cnt = 0, acc_first_cyc = 0, acc_last_cyc = 0, ret_cyc = 0;
  int   rel_budget = 1000;
  logic spur = 1'b0;
  logic acc0_s = 1'b0, acc1_s = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Requester agents and SRAM return model, driven just after the edge.
  always @(posedge clk) begin
    ret_t r;
    #1;
    if (acc0_s && q0.size() > 0) void'(q0.pop_front());
    if (acc1_s && q1.size() > 0) void'(q1.pop_front());
    if (q0.size() > 0) begin
      m0_req = 1'b1; m0_rd = q0[0].rd; m0_addr = q0[0].addr;
      m0_be = 2'b11; m0_wr_data = q0[0].wd;
    end else m0_req = 1'b0;
    if (q1.size() > 0) begin
      m1_req = 1'b1; m1_rd = q1[0].rd; m1_addr = q1[0].addr;
      m1_be = 2'b11; m1_wr_data = q1[0].wd;
    end else m1_req = 1'b0;
    if (spur) begin
      sram_rd_data_vld = 1'b1; sram_rd_data = 16'hDEAD;
    end else if (retq.size() > 0 && rel_budget > 0 && retq[0].due <= 32'(cyc)) begin
      r = retq.pop_front();
      sram_rd_data_vld = 1'b1; sram_rd_data = r.data;
      rel_budget--;
    end else begin
      sram_rd_data_vld = 1'b0;
    end
  end

  // Monitor: grant scoreboard, read-return scoreboard, SRAM storage.
  always @(negedge clk) begin
    gnt_t g;
    rdx_t x;
    acc0_s = m0_req && m0_ready;
    acc1_s = m1_req && m1_ready;
    if (!reset && sram_req && sram_ready) begin
      acc_cnt++;
      if (acc_cnt == 1) acc_first_cyc = cyc;
      acc_last_cyc = cyc;
      if (sram_rd) retq.push_back({32'(cyc + 4), mem[sram_addr[7:0]]});
      else         mem[sram_addr[7:0]] = sram_wr_data;
      if (gexp.size() == 0) check("gnt_extra", 32'(sram_addr), 32'h3ffff + 1);
      else begin
        g = gexp.pop_front();
        check("gnt_id", {30'd0, acc1_s, acc0_s}, g.id ? 32'd2 : 32'd1);
        check("gnt_addr", 32'(sram_addr), 32'(g.addr));
      end
    end
    if (m0_rd_data_vld || m1_rd_data_vld) begin
      ret_cyc = cyc;
      if (rexp.size() == 0) check("rd_extra", {30'd0, m1_rd_data_vld, m0_rd_data_vld}, 32'd0);
      else begin
        x = rexp.pop_front();
        check("rd_vld", {30'd0, m1_rd_data_vld, m0_rd_data_vld}, x.id ? 32'd2 : 32'd1);
        check("rd_data", 32'(x.id ? m1_rd_data : m0_rd_data), 32'(x.data));
      end
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic push_cmd(input logic id, input logic rd, input logic [17:0] addr,
                          input logic [15:0] wd);
    if (id) q1.push_back({rd, addr, wd});
    else    q0.push_back({rd, addr, wd});
  endtask

  task automatic exp_gnt(input logic id, input logic [17:0] addr);
    gexp.push_back({id, addr});
  endtask

  task automatic exp_rd(input logic id, input logic [15:0] data);
    rexp.push_back({id, data});
  endtask

  task automatic drain(input string tag, input int lim);
    int n = 0;
    while ((q0.size() + q1.size() + gexp.size() + rexp.size()) > 0 && n < lim) begin
      step();
      n++;
    end
    check(tag, 32'(n < lim), 32'd1);
  endtask

  task automatic reset_dut();
    step();
    reset = 1'b1;
    q0.delete(); q1.delete(); gexp.delete(); rexp.delete(); retq.delete();
    spur = 1'b0; rel_budget = 1000; sram_ready = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    acc_cnt = 0;
    @(negedge clk);
    check("rst_ctl", {26'd0, m0_ready, m1_ready, sram_req, m0_rd_data_vld,
                      m1_rd_data_vld, rd_err}, 32'd0);
    check("rst_fields", {sram_rd, sram_addr, sram_be, sram_wr_data} == '0 ? 32'd0 : 32'd1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    mem[8'h10] = 16'hAAAA;
    mem[8'h20] = 16'hBBBB;

    // Reset-first priority and gapless alternation (or bursts of 4).
    reset_dut();
    step();
    for (int i = 0; i < 8; i++) begin
      push_cmd(1'b0, 1'b0, 18'h80 + 18'(i), 16'h5000 + 16'(i));
      push_cmd(1'b1, 1'b0, 18'hC0 + 18'(i), 16'h6000 + 16'(i));
    end
`ifdef SRAM_ARB_BURST_EN
    for (int b = 0; b < 2; b++) begin
      for (int j = 0; j < 4; j++) exp_gnt(1'b0, 18'h80 + 18'(4 * b + j));
      for (int j = 0; j < 4; j++) exp_gnt(1'b1, 18'hC0 + 18'(4 * b + j));
    end
`else
    for (int i = 0; i < 8; i++) begin
      exp_gnt(1'b0, 18'h80 + 18'(i));
      exp_gnt(1'b1, 18'hC0 + 18'(i));
    end
`endif
    p = cyc;
    drain("t1_drain", 60);
    check("t1_count", 32'(acc_cnt), 32'd16);
    check("t1_latency", 32'(acc_first_cyc - p), 32'd2);
    check("t1_nogap", 32'(acc_last_cyc - acc_first_cyc), 32'd15);

    // Read steering back to the issuing requester.
    reset_dut();
    step();
    push_cmd(1'b0, 1'b1, 18'h10, 16'h0);
    push_cmd(1'b1, 1'b1, 18'h20, 16'h0);
    exp_gnt(1'b0, 18'h10);
    exp_gnt(1'b1, 18'h20);
    exp_rd(1'b0, 16'hAAAA);
    exp_rd(1'b1, 16'hBBBB);
    drain("t2_drain", 40);

    // FIFO full blocks the fifth read until one return pops a tag.
    reset_dut();
    rel_budget = 0;
    step();
    for (int i = 0; i < 5; i++) begin
      push_cmd(1'b0, 1'b1, 18'h30 + 18'(i), 16'h0);
      exp_gnt(1'b0, 18'h30 + 18'(i));
      exp_rd(1'b0, 16'h1030 + 16'(i));
    end
    repeat (12) step();
    @(negedge clk);
    check("t3_acc4", 32'(acc_cnt), 32'd4);
    check("t3_blocked", {29'd0, m0_req, m0_ready, sram_req}, 32'd4);
    step();
    rel_budget = 1;
    begin
      int n = 0;
      while (acc_cnt < 5 && n < 20) begin step(); n++; end
      check("t3_fifth", 32'(n < 20), 32'd1);
    end
    check("t3_unblock", 32'(acc_last_cyc - ret_cyc), 32'd1);
    rel_budget = 1000;
    drain("t3_drain", 60);

    // Stall stability: grant and fields hold while the owner is unaccepted.
    reset_dut();
    sram_ready = 1'b0;
    step();
    push_cmd(1'b0, 1'b0, 18'h40, 16'h4444);
    exp_gnt(1'b0, 18'h40);
    repeat (3) step();
    push_cmd(1'b1, 1'b0, 18'h50, 16'h5555);
    exp_gnt(1'b1, 18'h50);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t4_hold", {12'd0, sram_req, m1_ready, sram_addr}, {12'd0, 1'b1, 1'b0, 18'h40});
    end
    step();
    sram_ready = 1'b1;
    drain("t4_drain", 20);

    // Spurious return: dropped, flagged, sticky until reset.
    reset_dut();
    step();
    spur = 1'b1;
    step();
    spur = 1'b0;
    @(negedge clk);
    check("t5_vld", {30'd0, m0_rd_data_vld, m1_rd_data_vld}, 32'd0);
    check("t5_err_pre", 32'(rd_err), 32'd0);
    step();
    @(negedge clk);
    check("t5_err", 32'(rd_err), 32'd1);
    repeat (5) step();
    check("t5_err_sticky", 32'(rd_err), 32'd1);
    reset_dut();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
